// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory responder.
// Consumers: dmem_array, dmem_responder.
package dmem_pkg;

    // Width of the wait-state counter (WAIT_CYCLES is limited to 0..15)
    localparam int unsigned CNT_W = 4;

    // Default test-monitor addresses/data
    localparam logic [31:0] DEF_PASS_ADDR   = 32'd84;
    localparam logic [31:0] DEF_PASS_DATA   = 32'd7;
    localparam logic [31:0] DEF_IGNORE_ADDR = 32'd80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage: combinational read, synchronous write.
// Contents are intentionally not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64
) (
    input  logic                           clk,
    input  logic                           we_i,
    input  logic [$clog2(DEPTH_WORDS)-1:0] idx_i,
    input  logic [31:0]                    wdata_i,
    output logic [31:0]                    rdata_o
);

    logic [31:0] mem_q [DEPTH_WORDS];

    // Commit a write on the rising edge ending the access cycle
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Wait-state data-memory responder for a pipelined CPU M-stage, with an
// optional test-result monitor (done/fail) compiled in when the macro
// DMEM_MONITOR_EN is defined; otherwise done/fail are tied low.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] PASS_ADDR   = DEF_PASS_ADDR,
    parameter logic [31:0] PASS_DATA   = DEF_PASS_DATA,
    parameter logic [31:0] IGNORE_ADDR = DEF_IGNORE_ADDR
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memread,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        stall,
    output logic        addr_err,
    output logic        done,
    output logic        fail
);

    localparam int unsigned     AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0]     MEM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic            ZERO_WAIT = (WAIT_CYCLES == 0);
    // Counter holds the number of WAIT cycles still to spend; the IDLE
    // cycle that sees the request already counts as the first stall.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    logic        req;
    logic        is_store;
    logic        is_load;
    logic        addr_ok;
    logic        access;
    logic        we;
    logic [31:0] arr_rdata;

    assign req      = memread | memwrite;
    assign is_store = memwrite;
    assign is_load  = memread & ~memwrite;
    assign addr_ok  = (dataadr[1:0] == 2'b00) && (dataadr < MEM_BYTES);

    // Wait-state sequencer: IDLE -> WAIT (count down) -> RESP -> IDLE.
    // With WAIT_CYCLES==1 the single stall is the IDLE cycle, so WAIT is
    // skipped; with WAIT_CYCLES==0 the sequencer never leaves IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && !ZERO_WAIT) begin
                        cnt_q   <= CNT_LOAD;
                        state_q <= (CNT_LOAD == '0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    if (!req) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q <= CNT_W'(1)) begin
                        state_q <= RESP;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // Stall and access-cycle decode
    always_comb begin
        stall  = 1'b0;
        access = 1'b0;
        case (state_q)
            IDLE: begin
                if (req) begin
                    if (ZERO_WAIT) access = 1'b1;
                    else           stall  = 1'b1;
                end
            end
            WAIT:    stall  = 1'b1;
            RESP:    access = req;
            default: ;
        endcase
    end

    assign we       = access & is_store & addr_ok & rst;
    assign addr_err = access & ~addr_ok & rst;
    assign readdata = (access && is_load && addr_ok) ? arr_rdata : '0;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_array (
        .clk     (clk),
        .we_i    (we),
        .idx_i   (dataadr[AW+1:2]),
        .wdata_i (writedata),
        .rdata_o (arr_rdata)
    );

`ifdef DMEM_MONITOR_EN
    logic done_q;
    logic fail_q;

    // Sticky test-result flags, updated by committed stores only
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q <= 1'b0;
            fail_q <= 1'b0;
        end else if (we) begin
            if (dataadr == PASS_ADDR && writedata == PASS_DATA) begin
                done_q <= 1'b1;
            end else if (dataadr != IGNORE_ADDR) begin
                fail_q <= 1'b1;
            end
        end
    end

    assign done = done_q;
    assign fail = fail_q;
`else
    logic unused_monitor_cfg;
    assign unused_monitor_cfg = ^{PASS_ADDR, PASS_DATA, IGNORE_ADDR};
    assign done = 1'b0;
    assign fail = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait
// states, one with zero wait states, checked against a word-array model.
module tb_dmem_responder;

`ifdef DMEM_MONITOR_EN
    localparam bit MON = 1'b1;
`else
    localparam bit MON = 1'b0;
`endif

    logic        clk;
    logic        rst;

    logic        wr_a, rd_a, stall_a, aerr_a, done_a, fail_a;
    logic [31:0] adr_a, wd_a, rdata_a;
    logic        wr_b, rd_b, stall_b, aerr_b, done_b, fail_b;
    logic [31:0] adr_b, wd_b, rdata_b;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference model: word contents and expected sticky flags per instance
    logic [31:0] mdl [2][64];
    bit          exp_done [2];
    bit          exp_fail [2];

    dmem_responder #(
        .DEPTH_WORDS(64),
        .WAIT_CYCLES(2)
    ) dut_a (
        .clk       (clk),
        .rst       (rst),
        .memread   (rd_a),
        .memwrite  (wr_a),
        .dataadr   (adr_a),
        .writedata (wd_a),
        .readdata  (rdata_a),
        .stall     (stall_a),
        .addr_err  (aerr_a),
        .done      (done_a),
        .fail      (fail_a)
    );

    dmem_responder #(
        .DEPTH_WORDS(64),
        .WAIT_CYCLES(0)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .memread   (rd_b),
        .memwrite  (wr_b),
        .dataadr   (adr_b),
        .writedata (wd_b),
        .readdata  (rdata_b),
        .stall     (stall_b),
        .addr_err  (aerr_b),
        .done      (done_b),
        .fail      (fail_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_valid(input logic [31:0] a);
        return (a % 4 == 0) && (a < 256);
    endfunction

    function automatic logic [31:0] exp_rdata(input int d, input logic wr, input logic rd,
                                              input logic [31:0] a);
        if (rd && !wr && addr_valid(a)) return mdl[d][a / 4];
        return 32'h0;
    endfunction

    function automatic logic [31:0] exp_err(input logic wr, input logic rd, input logic [31:0] a);
        return ((wr || rd) && !addr_valid(a)) ? 32'h1 : 32'h0;
    endfunction

    task automatic commit(input int d, input logic wr, input logic [31:0] a, input logic [31:0] data);
        if (wr && addr_valid(a)) begin
            mdl[d][a / 4] = data;
            if (a == 84 && data == 7) exp_done[d] = 1'b1;
            else if (a != 80)         exp_fail[d] = 1'b1;
        end
    endtask

    function automatic logic [31:0] rnd_addr();
        int unsigned r;
        r = $urandom_range(0, 9);
        if (r == 0) return 32'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
        if (r == 1) return 32'(256 + $urandom_range(0, 1000) * 4);
        return 32'($urandom_range(0, 63) * 4);
    endfunction

    // One complete access on the two-wait-state instance; starts just after
    // a falling edge and ends on the falling edge after the access cycle.
    task automatic access_a(input string tag, input logic wr, input logic rd,
                            input logic [31:0] a, input logic [31:0] wd);
        int unsigned n;
        wr_a = wr; rd_a = rd; adr_a = a; wd_a = wd;
        #2;
        n = 0;
        while (stall_a === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #2;
        end
        chk({tag, "-stalls"}, 32'(n), (wr || rd) ? 32'd2 : 32'd0);
        chk({tag, "-rdata"}, rdata_a, exp_rdata(0, wr, rd, a));
        chk({tag, "-aerr"}, 32'(aerr_a), exp_err(wr, rd, a));
        commit(0, wr, a, wd);
        @(negedge clk);
        wr_a = 1'b0; rd_a = 1'b0;
        chk({tag, "-done"}, 32'(done_a), 32'(MON && exp_done[0]));
        chk({tag, "-fail"}, 32'(fail_a), 32'(MON && exp_fail[0]));
    endtask

    initial begin
        logic        wr, rd;
        logic [31:0] a, wd, old20;

        rst = 1'b0;
        wr_a = 1'b0; rd_a = 1'b0; adr_a = '0; wd_a = '0;
        wr_b = 1'b0; rd_b = 1'b0; adr_b = '0; wd_b = '0;
        exp_done = '{default: 1'b0};
        exp_fail = '{default: 1'b0};

        // Reset state
        #2;
        chk("rst-stall-a", 32'(stall_a), 32'h0);
        chk("rst-aerr-a",  32'(aerr_a),  32'h0);
        chk("rst-done-a",  32'(done_a),  32'h0);
        chk("rst-fail-a",  32'(fail_a),  32'h0);
        chk("rst-rdata-a", rdata_a,      32'h0);
        chk("rst-done-b",  32'(done_b),  32'h0);
        chk("rst-fail-b",  32'(fail_b),  32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;

        // Monitor sequence: pass word, ignored word, then a failing store
        access_a("pass84",   1'b1, 1'b0, 32'd84, 32'd7);
        access_a("ign80",    1'b1, 1'b0, 32'd80, 32'd5);
        access_a("fail88",   1'b1, 1'b0, 32'd88, 32'd1);
        access_a("ld84",     1'b0, 1'b1, 32'd84, 32'd0);

        // Store then load with wait states, back to back
        access_a("st10",     1'b1, 1'b0, 32'h10, 32'hDEADBEEF);
        access_a("ld10",     1'b0, 1'b1, 32'h10, 32'h0);

        // Fill the remaining words so every load has a known expectation
        for (int unsigned i = 0; i < 64; i++) begin
            if (i != 4 && i != 20 && i != 21 && i != 22)
                access_a("fill-a", 1'b1, 1'b0, 32'(i * 4), $urandom);
        end

        // Misaligned / out-of-range accesses leave the array untouched
        access_a("ld13",     1'b0, 1'b1, 32'h13,  32'h0);
        access_a("st400",    1'b1, 1'b0, 32'h400, $urandom);
        access_a("ld0",      1'b0, 1'b1, 32'h0,   32'h0);
        access_a("st12",     1'b1, 1'b0, 32'h12,  $urandom);
        access_a("ld10b",    1'b0, 1'b1, 32'h10,  32'h0);
        access_a("both-hi",  1'b1, 1'b1, 32'h30,  32'h12345678);
        access_a("ld30",     1'b0, 1'b1, 32'h30,  32'h0);

        // Random accesses on the wait-state instance
        for (int unsigned i = 0; i < 30; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = ~wr | 1'($urandom_range(0, 1));
            access_a("rnd-a", wr, rd, rnd_addr(), $urandom);
        end

        // Reset while a store sits in WAIT: no commit, flags cleared
        old20 = mdl[0][8];
        wr_a = 1'b1; adr_a = 32'h20; wd_a = ~old20;
        @(negedge clk);
        #1;
        rst = 1'b0;
        wr_a = 1'b0;
        exp_done = '{default: 1'b0};
        exp_fail = '{default: 1'b0};
        #1;
        chk("rstwait-stall", 32'(stall_a), 32'h0);
        chk("rstwait-done",  32'(done_a),  32'h0);
        chk("rstwait-fail",  32'(fail_a),  32'h0);
        chk("rstwait-aerr",  32'(aerr_a),  32'h0);
        @(negedge clk);
        rst = 1'b1;
        access_a("ld20", 1'b0, 1'b1, 32'h20, 32'h0);

        // Store abandoned mid-WAIT: no write, no flags
        wr_a = 1'b1; adr_a = 32'h24; wd_a = ~mdl[0][9];
        @(negedge clk);
        wr_a = 1'b0;
        @(negedge clk);
        #2;
        chk("drop-stall", 32'(stall_a), 32'h0);
        chk("drop-fail",  32'(fail_a),  32'h0);
        @(negedge clk);
        access_a("ld24", 1'b0, 1'b1, 32'h24, 32'h0);

        // Zero-wait instance: fill every word, one store per cycle
        for (int unsigned i = 0; i < 64; i++) begin
            wr_b = 1'b1; rd_b = 1'b0; adr_b = 32'(i * 4); wd_b = $urandom;
            #2;
            chk("fill-b-stall", 32'(stall_b), 32'h0);
            chk("fill-b-aerr",  32'(aerr_b),  32'h0);
            commit(1, wr_b, adr_b, wd_b);
            @(negedge clk);
        end

        // Zero-wait instance: random back-to-back loads and stores
        for (int unsigned i = 0; i < 200; i++) begin
            wr = 1'($urandom_range(0, 1));
            rd = 1'($urandom_range(0, 1));
            a  = rnd_addr();
            wd = $urandom;
            wr_b = wr; rd_b = rd; adr_b = a; wd_b = wd;
            #2;
            chk("rnd-b-stall", 32'(stall_b), 32'h0);
            chk("rnd-b-rdata", rdata_b, exp_rdata(1, wr, rd, a));
            chk("rnd-b-aerr",  32'(aerr_b), exp_err(wr, rd, a));
            commit(1, wr, a, wd);
            @(negedge clk);
        end
        wr_b = 1'b0; rd_b = 1'b0;
        #2;
        chk("end-b-done", 32'(done_b), 32'(MON && exp_done[1]));
        chk("end-b-fail", 32'(fail_b), 32'(MON && exp_fail[1]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64, number of 32-bit words stored (power of two, >=4).
REQ-002 Parameter WAIT_CYCLES, default 2, stall cycles inserted per access (0..15).
REQ-003 Parameter PASS_ADDR, default 84, byte address of the test-result word.
REQ-004 Parameter PASS_DATA, default 7, value that signals test success.
REQ-005 Parameter IGNORE_ADDR, default 80, byte address exempt from fail detection.
REQ-006 clk  in  1  sole clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous, active-low.
REQ-008 memread  in  1  CPU M-stage load request.
REQ-009 memwrite  in  1  CPU M-stage store request.
REQ-010 dataadr  in  32  byte address from CPU.
REQ-011 writedata  in  32  store data from CPU.
REQ-012 readdata  out  32  load data to CPU.
REQ-013 stall  out  1  holds the CPU pipeline while an access is pending.
REQ-014 addr_err  out  1  one-cycle pulse on misaligned or out-of-range access completion.
REQ-015 done  out  1  sticky test-pass flag.
REQ-016 fail  out  1  sticky test-fail flag.

Function
REQ-017 Request = memread|memwrite; memwrite has priority when both are high (treated as store, readdata=0).
REQ-018 FSM states IDLE, WAIT, RESP; counter width 4 bits.
REQ-019 IDLE + request + WAIT_CYCLES>0: stall=1 combinationally that cycle; next state WAIT, counter=WAIT_CYCLES-1.
REQ-020 WAIT: stall=1; counter decrements each cycle; at counter==0 next state RESP.
REQ-021 RESP: stall=0; access performed this cycle; next state IDLE.
REQ-022 WAIT_CYCLES==0: access performed in IDLE with stall=0; FSM never leaves IDLE.
REQ-023 Store commits to the array on the rising edge ending the access cycle; load returns array[dataadr index] combinationally in the access cycle, readdata=0 otherwise.
REQ-024 Back-to-back requests: a new request seen in IDLE directly after RESP starts a fresh wait sequence; no bubble beyond WAIT_CYCLES stalls per access.
REQ-025 Request dropped while in WAIT: return to IDLE next cycle, no write, no flags.
REQ-026 CPU holds dataadr/writedata stable while stall=1; responder samples them in the access cycle only.
REQ-027 Index = dataadr[log2(DEPTH_WORDS)+1:2]; dataadr[1:0]!=0 or dataadr>=4*DEPTH_WORDS: store dropped, load returns 0, addr_err pulses in the access cycle.
REQ-028 Committed store with dataadr==PASS_ADDR and writedata==PASS_DATA sets done.
REQ-029 Committed store to any address other than PASS_ADDR and IGNORE_ADDR, or to PASS_ADDR with other data, sets fail.
REQ-030 done and fail never clear except by reset; both may be set.

Reset
REQ-031 rst low: state=IDLE, counter=0, done=0, fail=0, addr_err=0, immediately and asynchronously.
REQ-032 stall and readdata follow REQ-019..023 from IDLE during/after reset; array contents are not reset.
REQ-033 Reset during WAIT or RESP aborts the access; no store commits.

Configuration
REQ-034 Macro DMEM_MONITOR_EN defined: done/fail logic per REQ-028..030 is compiled in.
REQ-035 DMEM_MONITOR_EN undefined: done and fail tied to 0, no monitor registers; all other behaviour identical.

Structure
REQ-036 Package dmem_pkg holds the state enum (IDLE/WAIT/RESP), default PASS_ADDR/PASS_DATA/IGNORE_ADDR constants, counter width.
REQ-037 Storage is sub-module dmem_array (single-port, combinational read, synchronous write, DEPTH_WORDS param); FSM and monitor live in dmem_responder.

Verification
REQ-038 WAIT_CYCLES=2, store 0xDEADBEEF @0x10 -> stall high 2 cycles, low 1; subsequent load @0x10 returns 0xDEADBEEF after 2 stall cycles.
REQ-039 Store 7 @84 -> done=1 next cycle, fail=0; store 5 @80 -> fail stays 0; store 1 @88 -> fail=1.
REQ-040 WAIT_CYCLES=0, loads/stores back-to-back every cycle -> stall never asserted, data matches reference model.
REQ-041 Load @0x13 and store @0x400 (DEPTH 64) -> addr_err pulses once each, array unchanged, readdata=0.
REQ-042 rst low in WAIT of store @0x20 -> state IDLE, done/fail 0, word @0x20 unchanged; memwrite dropped mid-WAIT -> same, no write.
REQ-043 Without DMEM_MONITOR_EN, store 7 @84 -> done=0, fail=0, word stored.
